// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        i_byte;
    logic              i_valid;
    logic              o_ready;
    logic              i_restart;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [15:0]       o_wdata;
    logic              o_cpu_rst;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_byte, i_valid, i_restart,
        output o_ready, o_we, o_waddr, o_wdata, o_cpu_rst, o_done, o_err
    );

    modport master (
        output i_byte, i_valid, i_restart,
        input  o_ready, o_we, o_waddr, o_wdata, o_cpu_rst, o_done, o_err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    imem_loader_if.slave   bus
);
    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE, ERR
    } state_t;

    typedef struct packed {
        logic ready;
        logic cpu_rst;
        logic done;
        logic err;
    } flags_t;

    function automatic flags_t flags_of(state_t s);
        flags_t f;
        f.ready   = (s != DONE) && (s != ERR);
        f.cpu_rst = (s != DONE);
        f.done    = (s == DONE);
        f.err     = (s == ERR);
        return f;
    endfunction

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif
    localparam logic [31:0] MAX_W32 = MAX_WORDS;

    state_t            state;
    flags_t            flags;
    logic [7:0]        hi;
    logic [15:0]       len;
    logic [15:0]       widx;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       wdata;
    logic [15:0]       len_in;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign len_in = {hi, bus.i_byte};

    // Outputs are computed from the destination state at each transition, so all are registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= LEN_HI;
            flags <= flags_of(LEN_HI);
            hi    <= '0;
            len   <= '0;
            widx  <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            we <= 1'b0;
            case (state)
                DONE, ERR: begin
                    if (bus.i_restart) begin
                        state <= LEN_HI;
                        flags <= flags_of(LEN_HI);
                        widx  <= '0;
                        waddr <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                default: begin
                    // Every non-terminal state is ready, so i_valid alone means a transfer.
                    if (bus.i_valid) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.i_byte;
`endif
                        case (state)
                            LEN_HI: begin
                                hi    <= bus.i_byte;
                                state <= LEN_LO;
                                flags <= flags_of(LEN_LO);
                            end
                            LEN_LO: begin
                                len <= len_in;
                                if (len_in == 16'd0) begin
                                    state <= END_STATE;
                                    flags <= flags_of(END_STATE);
                                end else if ({16'd0, len_in} > MAX_W32) begin
                                    state <= ERR;
                                    flags <= flags_of(ERR);
                                end else begin
                                    state <= DATA_HI;
                                    flags <= flags_of(DATA_HI);
                                end
                            end
                            DATA_HI: begin
                                hi    <= bus.i_byte;
                                state <= DATA_LO;
                                flags <= flags_of(DATA_LO);
                            end
                            DATA_LO: begin
                                we    <= 1'b1;
                                wdata <= {hi, bus.i_byte};
                                waddr <= ADDR_W'(widx);
                                widx  <= widx + 16'd1;
                                if (widx + 16'd1 == len) begin
                                    state <= END_STATE;
                                    flags <= flags_of(END_STATE);
                                end else begin
                                    state <= DATA_HI;
                                    flags <= flags_of(DATA_HI);
                                end
                            end
`ifdef LOADER_CHECKSUM_EN
                            CHK: begin
                                if (bus.i_byte == csum) begin
                                    state <= DONE;
                                    flags <= flags_of(DONE);
                                end else begin
                                    state <= ERR;
                                    flags <= flags_of(ERR);
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.o_ready   = flags.ready;
    assign bus.o_cpu_rst = flags.cpu_rst;
    assign bus.o_done    = flags.done;
    assign bus.o_err     = flags.err;
    assign bus.o_we      = we;
    assign bus.o_waddr   = waddr;
    assign bus.o_wdata   = wdata;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed table, hand sequences, random streams vs model.
module tb_imem_loader;
    localparam int MAXW = 4;
    localparam int AW   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW)) bus();
    imem_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  stim[$];
    logic        m_done, m_err;

    // Capture every write strobe well after the edge that produced it.
    always @(posedge clk) begin
        #2;
        if (bus.o_we === 1'b1) got_q.push_back({bus.o_waddr, bus.o_wdata});
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; byte is presented for one rising edge.
    task automatic send(input logic [7:0] b, input int gap);
        bus.i_valid = 1'b0;
        repeat (gap) @(negedge clk);
        check("ready_before_byte", {31'd0, bus.o_ready}, 32'd1);
        bus.i_byte  = b;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Reference: length prefix, big-endian words, optional XOR of all prior bytes.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = {stim[0], stim[1]};
        x = 8'h00;
        if (n > MAXW) begin
            m_done = 1'b0;
            m_err  = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) exp_q.push_back({16'(i), stim[2+2*i], stim[3+2*i]});
`ifdef LOADER_CHECKSUM_EN
        for (int i = 0; i < 2 + 2*n; i++) x = x ^ stim[i];
        m_done = (stim[2+2*n] == x);
        m_err  = !m_done;
`else
        m_done = 1'b1;
        m_err  = 1'b0;
`endif
    endtask

    task automatic add_chk(input logic corrupt);
        logic [7:0] x;
        int n;
        x = 8'h00;
        n = {stim[0], stim[1]};
`ifdef LOADER_CHECKSUM_EN
        if (n <= MAXW) begin
            foreach (stim[i]) x = x ^ stim[i];
            stim.push_back(x ^ (corrupt ? 8'h5A : 8'h00));
        end
`else
        if (corrupt && n < 0) stim.push_back(x);
`endif
    endtask

    task automatic check_end(input string nm, input logic exp_done, input logic exp_err);
        check({nm, "_done"},    {31'd0, bus.o_done},    {31'd0, exp_done});
        check({nm, "_err"},     {31'd0, bus.o_err},     {31'd0, exp_err});
        check({nm, "_cpu_rst"}, {31'd0, bus.o_cpu_rst}, {31'd0, !exp_done});
        check({nm, "_ready"},   {31'd0, bus.o_ready},   32'd0);
        check({nm, "_nwr"},     got_q.size(),           exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({nm, "_wr"}, got_q[i], exp_q[i]);
    endtask

    task automatic run(input string nm, input int maxgap);
        model();
        foreach (stim[i]) send(stim[i], $urandom_range(0, maxgap));
        check_end(nm, m_done, m_err);
    endtask

    task automatic restart();
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
        check("restart_ready",   {31'd0, bus.o_ready},   32'd1);
        check("restart_done",    {31'd0, bus.o_done},    32'd0);
        check("restart_err",     {31'd0, bus.o_err},     32'd0);
        check("restart_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
        check("restart_waddr",   {16'd0, bus.o_waddr},   32'd0);
        got_q.delete();
    endtask

    typedef struct {
        logic [7:0] b[10];
        int         nb;
        logic       exp_done;
        logic       exp_err;
        int         exp_nwr;
    } vec_t;

    vec_t tv[5];

    initial begin
        tv[0] = '{'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h00,8'h00,8'h00,8'h00}, 6, 1'b1, 1'b0, 2};
        tv[1] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 1'b1, 1'b0, 0};
        tv[2] = '{'{8'h00,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 1'b0, 1'b1, 0};
        tv[3] = '{'{8'h00,8'h04,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'hFE,8'hFF}, 10, 1'b1, 1'b0, 4};
        tv[4] = '{'{8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 1'b0, 1'b1, 0};

        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_byte = 8'h00;
        bus.i_restart = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready",   {31'd0, bus.o_ready},   32'd1);
        check("rst_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
        check("rst_done",    {31'd0, bus.o_done},    32'd0);
        check("rst_err",     {31'd0, bus.o_err},     32'd0);
        check("rst_we",      {31'd0, bus.o_we},      32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tv[k]) begin
            stim.delete();
            for (int i = 0; i < tv[k].nb; i++) stim.push_back(tv[k].b[i]);
            add_chk(1'b0);
            run($sformatf("vec%0d", k), 1);
            check($sformatf("vec%0d_tdone", k), {31'd0, bus.o_done}, {31'd0, tv[k].exp_done});
            check($sformatf("vec%0d_terr", k),  {31'd0, bus.o_err},  {31'd0, tv[k].exp_err});
            check($sformatf("vec%0d_tnwr", k),  got_q.size(),        tv[k].exp_nwr);
            if (k == 0) begin
                check("basic_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'h0000_1234);
                check("basic_w1", got_q.size() > 1 ? got_q[1] : 32'hX, 32'h0001_ABCD);
            end
            // Terminal states must hold without restart.
            repeat (3) @(negedge clk);
            check("sticky_done", {31'd0, bus.o_done}, {31'd0, tv[k].exp_done});
            check("sticky_err",  {31'd0, bus.o_err},  {31'd0, tv[k].exp_err});
            restart();
        end

        // Partial load with gaps, then reset that collides with a byte and a restart.
        send(8'h00, 3); send(8'h02, 3); send(8'h12, 3); send(8'h34, 3); send(8'hAB, 3);
        check("partial_nwr", got_q.size(), 1);
        check("partial_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'h0000_1234);
        rst = 1'b1; bus.i_valid = 1'b1; bus.i_byte = 8'hCD; bus.i_restart = 1'b1;
        @(negedge clk);
        check("midrst_we",      {31'd0, bus.o_we},      32'd0);
        check("midrst_waddr",   {16'd0, bus.o_waddr},   32'd0);
        check("midrst_wdata",   {16'd0, bus.o_wdata},   32'd0);
        check("midrst_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
        check("midrst_done",    {31'd0, bus.o_done},    32'd0);
        check("midrst_err",     {31'd0, bus.o_err},     32'd0);
        check("midrst_ready",   {31'd0, bus.o_ready},   32'd1);
        rst = 1'b0; bus.i_valid = 1'b0; bus.i_restart = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_nwr", got_q.size(), 1);
        got_q.delete();
        stim = '{8'h00, 8'h01, 8'h55, 8'h66};
        add_chk(1'b0);
        run("after_rst", 0);
        check("after_rst_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'h0000_5566);
        restart();

        // Restart mid-load is ignored.
        stim = '{8'h00, 8'h01, 8'h77, 8'h88};
        add_chk(1'b0);
        model();
        send(stim[0], 0); send(stim[1], 0);
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
        for (int i = 2; i < stim.size(); i++) send(stim[i], 0);
        check_end("restart_ignored", m_done, m_err);
        restart();

        for (int it = 0; it < 40; it++) begin
            int r;
            logic [15:0] n;
            r = $urandom_range(0, 9);
            n = (r <= 6) ? 16'(r) : (r == 7) ? 16'hFFFF : (r == 8) ? 16'h0100 : 16'h0004;
            stim.delete();
            stim.push_back(n[15:8]);
            stim.push_back(n[7:0]);
            if (n <= MAXW)
                for (int i = 0; i < 2 * int'(n); i++) stim.push_back(8'($urandom));
            add_chk($urandom_range(0, 3) == 0);
            run($sformatf("rnd%0d", it), 2);
            restart();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end
endmodule
